// File: rtl/mc_control_fsm.sv
// ============================================================================
// Module   : mc_control_fsm
// Desc     : Multicycle ARM control unit; decode, sequencing, NZCV and CondEx.
//            Define MC_MUL_EN to decode MUL (otherwise MUL is undecodable).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_control_fsm (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        MemWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [2:0]  ALUControl,
    output logic        Illegal,
    output logic [3:0]  State
);

    localparam logic [3:0] c_FETCH    = 4'd0;
    localparam logic [3:0] c_DECODE   = 4'd1;
    localparam logic [3:0] c_MEMADR   = 4'd2;
    localparam logic [3:0] c_MEMRD    = 4'd3;
    localparam logic [3:0] c_MEMWB    = 4'd4;
    localparam logic [3:0] c_MEMWR    = 4'd5;
    localparam logic [3:0] c_EXECUTER = 4'd6;
    localparam logic [3:0] c_EXECUTEI = 4'd7;
    localparam logic [3:0] c_ALUWB    = 4'd8;
    localparam logic [3:0] c_BRANCH   = 4'd9;
    localparam logic [3:0] c_UNKNOWN  = 4'd10;

    localparam logic [2:0] c_ALU_ADD  = 3'b000;
    localparam logic [2:0] c_ALU_SUB  = 3'b001;
    localparam logic [2:0] c_ALU_AND  = 3'b010;
    localparam logic [2:0] c_ALU_ORR  = 3'b011;
    localparam logic [2:0] c_ALU_MUL  = 3'b100;

    logic [3:0] state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       illegal_q, illegal_d;

    logic [1:0] w_op;
    logic       w_rd_pc;
    logic       w_mul_enc;
    logic       w_dp_ok;
    logic       w_is_cmp;
    logic [2:0] w_alu_op;
    logic       w_condex;
    logic       w_pcwrite, w_regwrite, w_irwrite, w_memwrite;
    logic       w_exec;

    assign w_op      = Instr[27:26];
    assign w_rd_pc   = (Instr[15:12] == 4'hF);
    assign w_mul_enc = (Instr[27:22] == 6'b000000) && (Instr[7:4] == 4'b1001);
    assign w_exec    = (state_q == c_EXECUTER) || (state_q == c_EXECUTEI);

    // MUL shares the AND cmd field, so its encoding is checked first.
    always_comb begin
        w_dp_ok  = 1'b0;
        w_is_cmp = 1'b0;
        w_alu_op = c_ALU_ADD;
        if (w_mul_enc) begin
`ifdef MC_MUL_EN
            w_dp_ok  = 1'b1;
            w_alu_op = c_ALU_MUL;
`else
            w_dp_ok  = 1'b0;
`endif
        end else begin
            case (Instr[24:21])
                4'b0000: begin w_dp_ok = 1'b1; w_alu_op = c_ALU_AND; end
                4'b0010: begin w_dp_ok = 1'b1; w_alu_op = c_ALU_SUB; end
                4'b0100: begin w_dp_ok = 1'b1; w_alu_op = c_ALU_ADD; end
                4'b1100: begin w_dp_ok = 1'b1; w_alu_op = c_ALU_ORR; end
                4'b1010: begin
                    w_dp_ok  = Instr[20];
                    w_is_cmp = 1'b1;
                    w_alu_op = c_ALU_SUB;
                end
                default: w_dp_ok = 1'b0;
            endcase
        end
    end

    always_comb begin
        case (Instr[31:28])
            4'b0000: w_condex = flags_q[2];
            4'b0001: w_condex = ~flags_q[2];
            4'b0010: w_condex = flags_q[1];
            4'b0011: w_condex = ~flags_q[1];
            4'b0100: w_condex = flags_q[3];
            4'b0101: w_condex = ~flags_q[3];
            4'b0110: w_condex = flags_q[0];
            4'b0111: w_condex = ~flags_q[0];
            4'b1000: w_condex = flags_q[1] & ~flags_q[2];
            4'b1001: w_condex = ~flags_q[1] | flags_q[2];
            4'b1010: w_condex = (flags_q[3] == flags_q[0]);
            4'b1011: w_condex = (flags_q[3] != flags_q[0]);
            4'b1100: w_condex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
            4'b1101: w_condex = flags_q[2] | (flags_q[3] != flags_q[0]);
            4'b1110: w_condex = 1'b1;
            default: w_condex = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= c_FETCH;
            flags_q   <= 4'b0000;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flags_q   <= flags_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        flags_d   = (w_exec && Instr[20]) ? ALUFlags : flags_q;
        case (state_q)
            c_FETCH:  state_d = c_DECODE;
            c_DECODE: begin
                if (!w_condex)          state_d = c_FETCH;
                else begin
                    case (w_op)
                        2'b00:   state_d = !w_dp_ok  ? c_UNKNOWN  :
                                           Instr[25] ? c_EXECUTEI : c_EXECUTER;
                        2'b01:   state_d = c_MEMADR;
                        2'b10:   state_d = c_BRANCH;
                        default: state_d = c_UNKNOWN;
                    endcase
                end
            end
            c_EXECUTER, c_EXECUTEI: state_d = w_is_cmp ? c_FETCH : c_ALUWB;
            c_MEMADR:  state_d = Instr[20] ? c_MEMRD : c_MEMWR;
            c_MEMRD:   state_d = c_MEMWB;
            c_ALUWB, c_MEMWB, c_MEMWR, c_BRANCH: state_d = c_FETCH;
            c_UNKNOWN: state_d = c_UNKNOWN;
            default:   state_d = c_FETCH;
        endcase
        illegal_d = illegal_q | (state_d == c_UNKNOWN);
    end

    always_comb begin
        w_pcwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_memwrite = 1'b0;
        AdrSrc     = 1'b0;
        RegSrc     = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ImmSrc     = 2'b00;
        ALUControl = c_ALU_ADD;
        case (state_q)
            c_FETCH: begin
                w_irwrite = 1'b1;
                w_pcwrite = 1'b1;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            c_DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                RegSrc    = {w_op == 2'b01, w_op == 2'b10};
            end
            c_EXECUTER: ALUControl = w_alu_op;
            c_EXECUTEI: begin
                ALUSrcB    = 2'b01;
                ALUControl = w_alu_op;
            end
            c_ALUWB: begin
                w_regwrite = 1'b1;
                w_pcwrite  = w_rd_pc;
            end
            c_MEMADR: begin
                ALUSrcB = 2'b01;
                ImmSrc  = 2'b01;
            end
            c_MEMRD: AdrSrc = 1'b1;
            c_MEMWB: begin
                ResultSrc  = 2'b01;
                w_regwrite = 1'b1;
                w_pcwrite  = w_rd_pc;
            end
            c_MEMWR: begin
                AdrSrc     = 1'b1;
                w_memwrite = 1'b1;
            end
            c_BRANCH: begin
                ALUSrcB   = 2'b01;
                ImmSrc    = 2'b10;
                ResultSrc = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // FETCH enables are active in the reset state, so mask all writes during reset.
    assign PCWrite  = w_pcwrite  & ~reset;
    assign RegWrite = w_regwrite & ~reset;
    assign IRWrite  = w_irwrite  & ~reset;
    assign MemWrite = w_memwrite & ~reset;
    assign Illegal  = illegal_q;
    assign State    = state_q;

endmodule

`default_nettype wire
